// File: rtl/pokey_cell_seq.sv
// Sequencer for load/clear strobes to a POKEY-style cell bank, paced by the slow-clock
// falling-edge pulse enn, with a timeout abort if the slow clock stops.
module pokey_cell_seq #(
  parameter int unsigned TMO = 63
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enn,
  input  logic       ld_req,
  input  logic [7:0] ld_data,
  output logic       ld_ack,
  input  logic       rst_req,
  output logic       rst_ack,
  output logic       err,
  output logic       busy,
  output logic [7:0] D,
  output logic       Ld,
  output logic       nLd,
  output logic       R
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACTIVE, S_GUARD} state_e;
  typedef enum logic       {OP_LOAD, OP_CLR} op_e;

  localparam logic [7:0] TMO_C = TMO[7:0];

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [7:0] d_q, d_d;
  logic       ld_q, ld_d;
  logic       r_q, r_d;
  logic       ld_ack_q, ld_ack_d;
  logic       rst_ack_q, rst_ack_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout;

  // The counter only advances outside IDLE and is zeroed on every enn, so it
  // can never pass TMO_C before the abort fires.
  assign timeout = (state_q != S_IDLE) && !enn && (cnt_q == TMO_C);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    d_d       = d_q;
    ld_d      = ld_q;
    r_d       = r_q;
    ld_ack_d  = 1'b0;
    rst_ack_d = 1'b0;
    err_d     = 1'b0;
    cnt_d     = enn ? 8'd0 : cnt_q + 8'd1;

    if (timeout) begin
      state_d = S_IDLE;
      ld_d    = 1'b0;
      r_d     = 1'b0;
      err_d   = 1'b1;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = 8'd0;
          // A request is not taken in the cycle its predecessor's ack is high.
          if (!ld_ack_q && !rst_ack_q) begin
            if (rst_req) begin
              op_d    = OP_CLR;
              state_d = S_ARM;
            end else if (ld_req) begin
              op_d    = OP_LOAD;
              d_d     = ld_data;
              state_d = S_ARM;
            end
          end
        end
        S_ARM: begin
          if (enn) begin
            state_d = S_ACTIVE;
            ld_d    = (op_q == OP_LOAD);
            r_d     = (op_q == OP_CLR);
          end
        end
        S_ACTIVE: begin
          if (enn) begin
            state_d = S_GUARD;
            ld_d    = 1'b0;
            r_d     = 1'b0;
          end
        end
        S_GUARD: begin
          if (enn) begin
            state_d   = S_IDLE;
            ld_ack_d  = (op_q == OP_LOAD);
            rst_ack_d = (op_q == OP_CLR);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset clears every register, including D to 8'hFF.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_LOAD;
      d_q       <= 8'hFF;
      ld_q      <= 1'b0;
      r_q       <= 1'b0;
      ld_ack_q  <= 1'b0;
      rst_ack_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      d_q       <= d_d;
      ld_q      <= ld_d;
      r_q       <= r_d;
      ld_ack_q  <= ld_ack_d;
      rst_ack_q <= rst_ack_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign D       = d_q;
  assign Ld      = ld_q;
  assign nLd     = ~ld_q;
  assign R       = r_q;
  assign ld_ack  = ld_ack_q;
  assign rst_ack = rst_ack_q;
  assign err     = err_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_pokey_cell_seq.sv
// Directed bench for pokey_cell_seq: enn every 28 clks, load/clear/timeout/reset scenarios
// with hand-computed expectations.
module tb_pokey_cell_seq;

  localparam int SEL_LD = 0, SEL_LD_ACK = 1, SEL_RST_ACK = 2, SEL_R = 3, SEL_ERR = 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic       enn;
  logic       ld_req;
  logic [7:0] ld_data;
  logic       ld_ack;
  logic       rst_req;
  logic       rst_ack;
  logic       err;
  logic       busy;
  logic [7:0] D;
  logic       Ld;
  logic       nLd;
  logic       R;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, last_enn_cyc = 0;
  int n_ld_cyc = 0, n_r_cyc = 0, n_ld_ack = 0, n_rst_ack = 0, n_err = 0;
  bit enn_run = 1'b0;

  pokey_cell_seq #(.TMO(63)) dut (
    .clk(clk), .nrst(nrst), .enn(enn),
    .ld_req(ld_req), .ld_data(ld_data), .ld_ack(ld_ack),
    .rst_req(rst_req), .rst_ack(rst_ack),
    .err(err), .busy(busy), .D(D), .Ld(Ld), .nLd(nLd), .R(R)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slow-clock falling-edge pulses: one clk wide, every 28 clks.
  initial begin
    int ph;
    ph  = 0;
    enn = 1'b0;
    forever begin
      @(negedge clk);
      ph  = (ph == 27) ? 0 : ph + 1;
      enn = enn_run && (ph == 0);
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (enn) last_enn_cyc = cyc;
  end

  // Per-cycle invariants and event tallies, sampled just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("ld_r_overlap", {31'd0, Ld & R}, 32'd0);
      check("nld_inv", {31'd0, nLd}, {31'd0, ~Ld});
      if (Ld === 1'b1) n_ld_cyc++;
      if (R === 1'b1) n_r_cyc++;
      if (ld_ack === 1'b1) n_ld_ack++;
      if (rst_ack === 1'b1) n_rst_ack++;
      if (err === 1'b1) n_err++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic sig(input int sel);
    case (sel)
      SEL_LD:      return Ld;
      SEL_LD_ACK:  return ld_ack;
      SEL_RST_ACK: return rst_ack;
      SEL_R:       return R;
      SEL_ERR:     return err;
      default:     return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_for(input string tag, input int sel, input int budget, output int n);
    n = 0;
    while (sig(sel) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, {31'd0, sig(sel)}, 32'd1);
  endtask

  task automatic do_load(input logic [7:0] v);
    int n;
    ld_req  = 1'b1;
    ld_data = v;
    wait_for("do_load_ack", SEL_LD_ACK, 120, n);
    ld_req = 1'b0;
    step();
  endtask

  initial begin
    int n, k, r0, l0, a0, e0;
    nrst    = 1'b0;
    ld_req  = 1'b0;
    ld_data = 8'h00;
    rst_req = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_D", {24'd0, D}, 32'hFF);
    check("rst_Ld", {31'd0, Ld}, 32'd0);
    check("rst_nLd", {31'd0, nLd}, 32'd1);
    check("rst_R", {31'd0, R}, 32'd0);
    check("rst_acks_err", {29'd0, ld_ack, rst_ack, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    nrst    = 1'b1;
    enn_run = 1'b1;
    repeat (5) step();

    // Load 8'h5A
    ld_req  = 1'b1;
    ld_data = 8'h5A;
    step();
    check("load_D_next", {24'd0, D}, 32'h5A);
    check("load_busy", {31'd0, busy}, 32'd1);
    wait_for("load_ld", SEL_LD, 40, n);
    check("load_ld_after_enn", cyc - last_enn_cyc, 32'd0);
    k = 0;
    while (Ld === 1'b1 && k < 60) begin
      step();
      k++;
    end
    check("load_ld_width", k, 32'd28);
    wait_for("load_ack", SEL_LD_ACK, 40, n);
    check("load_ack_delay", n, 32'd28);
    ld_req = 1'b0;
    step();
    check("load_ack_one_cycle", {31'd0, ld_ack}, 32'd0);
    check("load_idle", {31'd0, busy}, 32'd0);
    check("load_D_hold", {24'd0, D}, 32'h5A);
    check("load_ack_count", n_ld_ack, 32'd1);

    // Clear keeps D
    do_load(8'h00);
    r0 = n_r_cyc;
    rst_req = 1'b1;
    wait_for("clr_ack", SEL_RST_ACK, 120, n);
    rst_req = 1'b0;
    check("clr_r_width", n_r_cyc - r0, 32'd28);
    check("clr_D_kept", {24'd0, D}, 32'h00);
    step();

    // Simultaneous requests: clear first, then load
    r0 = n_r_cyc;
    l0 = n_ld_cyc;
    rst_req = 1'b1;
    ld_req  = 1'b1;
    ld_data = 8'h5A;
    wait_for("sim_rst_ack", SEL_RST_ACK, 120, n);
    rst_req = 1'b0;
    check("sim_r_first", n_r_cyc - r0, 32'd28);
    check("sim_no_ld_yet", n_ld_cyc - l0, 32'd0);
    check("sim_D_before_load", {24'd0, D}, 32'h00);
    wait_for("sim_ld_ack", SEL_LD_ACK, 120, n);
    ld_req = 1'b0;
    check("sim_ld_width", n_ld_cyc - l0, 32'd28);
    check("sim_D_loaded", {24'd0, D}, 32'h5A);
    step();

    // Timeout: enn stops while ACTIVE
    a0 = n_ld_ack;
    e0 = n_err;
    ld_req  = 1'b1;
    ld_data = 8'h3C;
    wait_for("tmo_ld", SEL_LD, 40, n);
    enn_run = 1'b0;
    wait_for("tmo_err", SEL_ERR, 100, n);
    // Counter is 0 the cycle after the last enn and reaches 63 at cycle 64;
    // err is registered, so it appears 64 edges after the enn edge.
    check("tmo_err_delay", cyc - last_enn_cyc, 32'd64);
    check("tmo_Ld", {31'd0, Ld}, 32'd0);
    check("tmo_nLd", {31'd0, nLd}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    ld_req = 1'b0;
    step();
    check("tmo_err_one_cycle", {31'd0, err}, 32'd0);
    check("tmo_err_count", n_err - e0, 32'd1);
    check("tmo_no_ack", n_ld_ack - a0, 32'd0);
    enn_run = 1'b1;
    step();

    // Reset mid-operation
    ld_req  = 1'b1;
    ld_data = 8'hA5;
    wait_for("mid_ld", SEL_LD, 40, n);
    repeat (3) step();
    a0 = n_ld_ack;
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_Ld", {31'd0, Ld}, 32'd0);
    check("mid_rst_nLd", {31'd0, nLd}, 32'd1);
    check("mid_rst_D", {24'd0, D}, 32'hFF);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    step();
    nrst = 1'b1;
    step();
    check("mid_reaccept_D", {24'd0, D}, 32'hA5);
    check("mid_reaccept_busy", {31'd0, busy}, 32'd1);
    check("mid_no_ack", n_ld_ack - a0, 32'd0);
    wait_for("mid_ack", SEL_LD_ACK, 120, n);
    ld_req = 1'b0;
    check("mid_ack_count", n_ld_ack - a0, 32'd1);
    step();

    // Back-to-back loads with ld_req held
    ld_req  = 1'b1;
    ld_data = 8'h11;
    wait_for("b2b_ack1", SEL_LD_ACK, 120, n);
    ld_data = 8'h22;
    step();
    check("b2b_no_accept_in_ack", {24'd0, D}, 32'h11);
    check("b2b_idle_after_ack", {31'd0, busy}, 32'd0);
    step();
    check("b2b_second_accept", {24'd0, D}, 32'h22);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_for("b2b_ack2", SEL_LD_ACK, 120, n);
    ld_req = 1'b0;
    step();
    check("b2b_D_final", {24'd0, D}, 32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pokey_cell_seq.md
POKEY_CELL_SEQ -- requirements
Module: pokey_cell_seq

Interface
REQ-001 The block SHALL have parameter TMO, default 63, giving the clk cycles without an enn pulse before an operation is aborted (legal range 32..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  50 MHz system clock; all state changes on its rising edge.
- nrst  in  1  asynchronous, active-low reset.
- enn  in  1  one-clk-cycle pulse marking each falling edge of the 1.79 MHz slow clock.
- ld_req  in  1  load request; held high until ld_ack.
- ld_data  in  8  load value; sampled when the load is accepted.
- ld_ack  out  1  one-cycle pulse when the load completes.
- rst_req  in  1  cell-reset request; held high until rst_ack.
- rst_ack  out  1  one-cycle pulse when the reset completes.
- err  out  1  one-cycle pulse when an operation is aborted by timeout.
- busy  out  1  high whenever state is not IDLE.
- D  out  8  data to the cell bank.
- Ld  out  1  load strobe to the cell bank.
- nLd  out  1  complement of Ld.
- R  out  1  reset strobe to the cell bank.

Function
REQ-003 The block SHALL implement the states IDLE, ARM, ACTIVE and GUARD, and SHALL track the operation type as LOAD or CLR.
REQ-004 In IDLE, when rst_req=1, the block SHALL select CLR and go to ARM, regardless of ld_req.
REQ-005 In IDLE, when rst_req=0 and ld_req=1, the block SHALL select LOAD, latch ld_data into D and go to ARM.
REQ-006 In ARM, on the first clk edge with enn=1, the block SHALL go to ACTIVE and assert Ld=1/nLd=0 for LOAD or R=1 for CLR; the strobe is therefore visible one clk after the enn pulse.
REQ-007 In ACTIVE, on the next enn pulse, the block SHALL deassert the strobe (Ld=0, nLd=1, R=0) and go to GUARD, so each strobe spans exactly one slow-clock period.
REQ-008 In GUARD, on the next enn pulse, the block SHALL pulse ld_ack for LOAD or rst_ack for CLR, for one cycle, and return to IDLE.
REQ-009 No new request SHALL be accepted in the cycle that ack is high; the earliest new accept is the cycle after.
REQ-010 Requests arriving while busy SHALL be left pending and not lost.
- On return to IDLE, a pending rst_req SHALL win over a pending ld_req.
- No operation SHALL be preempted.
REQ-011 D SHALL change only on LOAD acceptance and SHALL hold its value after the operation; a CLR operation SHALL NOT alter D.
REQ-012 Nld SHALL equal the inverse of Ld in every cycle, including during reset.
REQ-013 Ld and R SHALL never be high in the same cycle.
REQ-014 A timeout counter SHALL be cleared on entry to ARM, ACTIVE and GUARD and on every enn pulse, and SHALL count clk cycles otherwise.
REQ-015 When the counter reaches TMO with enn=0, the block SHALL:
- force Ld=0, nLd=1, R=0;
- pulse err for one cycle;
- issue no ack;
- return to IDLE, with the request still pending if it is still held.
REQ-016 An enn pulse in the same cycle as a request accept in IDLE SHALL NOT count as the ARM enn; ARM requires a later pulse.
REQ-017 A request dropped before its ack SHALL NOT abort an operation already in progress; the ack is still issued.

Reset
REQ-018 While nrst=0, independent of clk, the block SHALL force:
- state IDLE;
- D=8'hFF, Ld=0, nLd=1, R=0;
- ld_ack=0, rst_ack=0, err=0, busy=0;
- timeout counter cleared.
REQ-019 Asserting nrst mid-operation SHALL drop any active strobe immediately with no ack.
- After release, a request still held SHALL be serviced from IDLE as new.

Verification
REQ-020 The bench SHALL drive enn as one-clk pulses every 28 clk cycles and SHALL cover these directed scenarios:
- Load: ld_req=1, ld_data=8'h5A. Required: D=8'h5A the next cycle; Ld rises 1 clk after the next enn and stays high for 28 clks; ld_ack pulses 1 clk on the following enn edge.
- Simultaneous requests: rst_req=1 and ld_req=1 in the same cycle. Required: the R strobe completes first with rst_ack; then the load strobe runs with D=8'h5A and ld_ack; Ld and R never overlap.
- Clear keeps D: load 8'h00, then rst_req. Required: R high for exactly one slow period; D stays 8'h00.
- Timeout: stop enn while in ACTIVE. Required: err pulses after 63 clks; Ld=0 and nLd=1; no ld_ack; busy=0.
- Reset mid-operation: nrst=0 while Ld=1. Required: Ld=0, nLd=1 and D=8'hFF asynchronously; no ack; after release with ld_req still high, a fresh load sequence follows.
- Back-to-back loads with ld_req held continuously. Required: a second ld_data accept occurs no earlier than the cycle after ld_ack.
